// File: rtl/dallanma_cozucu_if.sv
// Branch/jump resolver bus: execute-side operation, PC-generator redirect,
// flush, link/exception pulses and statistics.
interface dallanma_cozucu_if #(parameter int SAYAC_BIT = 16);
  logic                 dal_gecerli_i;
  logic                 dal_hazir_o;
  logic [2:0]           dal_turu_i;
  logic [31:0]          adres_i;
  logic [31:0]          anlik_i;
  logic [31:0]          yazmac_degeri1_i;
  logic [31:0]          yazmac_degeri2_i;
  logic                 tahmin_atladi_i;
  logic [31:0]          tahmin_adres_i;
  logic                 yonlendir_gecerli_o;
  logic [31:0]          yonlendir_adres_o;
  logic                 yonlendir_hazir_i;
  logic                 temizle_o;
  logic                 baglanti_gecerli_o;
  logic [31:0]          baglanti_o;
  logic                 hizasiz_o;
  logic [SAYAC_BIT-1:0] dal_sayisi_o;
  logic [SAYAC_BIT-1:0] yanlis_tahmin_o;

  modport master (
    output dal_gecerli_i, dal_turu_i, adres_i, anlik_i, yazmac_degeri1_i,
           yazmac_degeri2_i, tahmin_atladi_i, tahmin_adres_i, yonlendir_hazir_i,
    input  dal_hazir_o, yonlendir_gecerli_o, yonlendir_adres_o, temizle_o,
           baglanti_gecerli_o, baglanti_o, hizasiz_o, dal_sayisi_o, yanlis_tahmin_o
  );

  modport slave (
    input  dal_gecerli_i, dal_turu_i, adres_i, anlik_i, yazmac_degeri1_i,
           yazmac_degeri2_i, tahmin_atladi_i, tahmin_adres_i, yonlendir_hazir_i,
    output dal_hazir_o, yonlendir_gecerli_o, yonlendir_adres_o, temizle_o,
           baglanti_gecerli_o, baglanti_o, hizasiz_o, dal_sayisi_o, yanlis_tahmin_o
  );
endinterface

// File: rtl/dallanma_cozucu.sv
// Branch/jump resolver: decides taken/target, compares with the fetch
// prediction, holds a redirect until accepted and then flushes.
module dallanma_cozucu #(
  parameter int TEMIZLE_CEVRIM = 2,
  parameter int SAYAC_BIT      = 16
) (
  input logic              clk_i,
  input logic              rst_ni,
  dallanma_cozucu_if.slave bus
);
  localparam int SW = (TEMIZLE_CEVRIM > 1) ? $clog2(TEMIZLE_CEVRIM + 1) : 1;

  typedef enum logic [1:0] {BOSTA, YONLENDIR, TEMIZLE} durum_t;

  typedef struct packed {
    logic        atla;
    logic [31:0] hedef;
    logic [31:0] sirali;
    logic        hizasiz;
    logic        yanlis;
  } karar_t;

  durum_t        durum;
  logic [SW-1:0] sayac;
  karar_t        k;
  logic          kabul;
  logic [31:0]   rs1, rs2;

  assign rs1   = bus.yazmac_degeri1_i;
  assign rs2   = bus.yazmac_degeri2_i;
  assign kabul = bus.dal_gecerli_i && bus.dal_hazir_o;

  always_comb begin
    k = '0;
    unique case (bus.dal_turu_i)
      3'd0:    k.atla = (rs1 == rs2);
      3'd1:    k.atla = (rs1 != rs2);
      3'd2:    k.atla = ($signed(rs1) <  $signed(rs2));
      3'd3:    k.atla = ($signed(rs1) >= $signed(rs2));
      3'd4:    k.atla = (rs1 <  rs2);
      3'd5:    k.atla = (rs1 >= rs2);
      default: k.atla = 1'b1;
    endcase
    k.hedef   = (bus.dal_turu_i == 3'd7) ? ((rs1 + bus.anlik_i) & ~32'd1)
                                         : (bus.adres_i + bus.anlik_i);
    k.sirali  = bus.adres_i + 32'd4;
    k.hizasiz = k.atla && (k.hedef[1:0] != 2'b00);
    k.yanlis  = (bus.tahmin_atladi_i != k.atla) ||
                (k.atla && (bus.tahmin_adres_i != k.hedef));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum                   <= BOSTA;
      sayac                   <= '0;
      bus.dal_hazir_o         <= 1'b0;
      bus.yonlendir_gecerli_o <= 1'b0;
      bus.yonlendir_adres_o   <= '0;
      bus.temizle_o           <= 1'b0;
      bus.baglanti_gecerli_o  <= 1'b0;
      bus.baglanti_o          <= '0;
      bus.hizasiz_o           <= 1'b0;
      bus.dal_sayisi_o        <= '0;
      bus.yanlis_tahmin_o     <= '0;
    end else begin
      bus.baglanti_gecerli_o <= 1'b0;
      bus.hizasiz_o          <= 1'b0;
      unique case (durum)
        BOSTA: begin
          bus.dal_hazir_o <= 1'b1;
          if (kabul) begin
            if (bus.dal_sayisi_o != '1) bus.dal_sayisi_o <= bus.dal_sayisi_o + 1'b1;
            if (bus.dal_turu_i[2:1] == 2'b11) begin
              bus.baglanti_gecerli_o <= 1'b1;
              bus.baglanti_o         <= k.sirali;
            end
            // a misaligned target raises the exception instead of redirecting
            if (k.hizasiz) begin
              bus.hizasiz_o <= 1'b1;
            end else if (k.yanlis) begin
              if (bus.yanlis_tahmin_o != '1) bus.yanlis_tahmin_o <= bus.yanlis_tahmin_o + 1'b1;
              durum                   <= YONLENDIR;
              bus.dal_hazir_o         <= 1'b0;
              bus.yonlendir_gecerli_o <= 1'b1;
              bus.yonlendir_adres_o   <= k.atla ? k.hedef : k.sirali;
              bus.temizle_o           <= 1'b1;
            end
          end
        end
        YONLENDIR: begin
          if (bus.yonlendir_hazir_i) begin
            bus.yonlendir_gecerli_o <= 1'b0;
            if (TEMIZLE_CEVRIM == 0) begin
              durum           <= BOSTA;
              bus.temizle_o   <= 1'b0;
              bus.dal_hazir_o <= 1'b1;
            end else begin
              durum <= TEMIZLE;
              sayac <= SW'(TEMIZLE_CEVRIM);
            end
          end
        end
        TEMIZLE: begin
          if (sayac <= SW'(1)) begin
            durum           <= BOSTA;
            bus.temizle_o   <= 1'b0;
            bus.dal_hazir_o <= 1'b1;
          end else begin
            sayac <= sayac - 1'b1;
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end
endmodule

// File: tb/tb_dallanma_cozucu.sv
// Bench for dallanma_cozucu: directed cases then random traffic, checked
// every cycle against a transaction-level reference model.
module tb_dallanma_cozucu;
  localparam int FL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dallanma_cozucu_if #(.SAYAC_BIT(16)) f();
  dallanma_cozucu_if #(.SAYAC_BIT(2))  g();

  assign g.dal_gecerli_i     = f.dal_gecerli_i;
  assign g.dal_turu_i        = f.dal_turu_i;
  assign g.adres_i           = f.adres_i;
  assign g.anlik_i           = f.anlik_i;
  assign g.yazmac_degeri1_i  = f.yazmac_degeri1_i;
  assign g.yazmac_degeri2_i  = f.yazmac_degeri2_i;
  assign g.tahmin_atladi_i   = f.tahmin_atladi_i;
  assign g.tahmin_adres_i    = f.tahmin_adres_i;
  assign g.yonlendir_hazir_i = f.yonlendir_hazir_i;

  dallanma_cozucu #(.TEMIZLE_CEVRIM(FL), .SAYAC_BIT(16)) dut  (.clk_i(clk), .rst_ni(rst_n), .bus(f.slave));
  dallanma_cozucu #(.TEMIZLE_CEVRIM(FL), .SAYAC_BIT(2))  dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(g.slave));

  int total = 0, bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state (redirect pending / flush cycles left)
  bit          m_pend, m_rdy, m_bg, m_hz;
  int          m_fl, m_cnt, m_mis;
  logic [31:0] m_addr, m_link;
  int          n_yv, n_tem;

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic ref_op(output bit tk, output logic [31:0] tg, output logic [31:0] nx);
    logic [31:0] a, b;
    a = f.yazmac_degeri1_i;
    b = f.yazmac_degeri2_i;
    case (f.dal_turu_i)
      3'd0: tk = (a == b);
      3'd1: tk = (a != b);
      3'd2: tk = ($signed(a) < $signed(b));
      3'd3: tk = !($signed(a) < $signed(b));
      3'd4: tk = (a < b);
      3'd5: tk = !(a < b);
      default: tk = 1'b1;
    endcase
    if (f.dal_turu_i == 3'd7) tg = (a + f.anlik_i) & 32'hFFFF_FFFE;
    else                      tg = f.adres_i + f.anlik_i;
    nx = tk ? tg : f.adres_i + 32'd4;
  endtask

  task automatic model_reset();
    m_pend = 0; m_rdy = 0; m_bg = 0; m_hz = 0;
    m_fl = 0; m_cnt = 0; m_mis = 0; m_addr = '0; m_link = '0;
  endtask

  // one clock: advance the model with the inputs now applied, then compare
  task automatic step();
    bit acc, hs, tk;
    logic [31:0] tg, nx;
    acc = f.dal_gecerli_i && m_rdy;
    hs  = m_pend && f.yonlendir_hazir_i;
    m_bg = 0; m_hz = 0;
    if (acc) begin
      ref_op(tk, tg, nx);
      m_cnt++;
      if (f.dal_turu_i >= 3'd6) begin m_bg = 1; m_link = f.adres_i + 32'd4; end
      if (tk && tg[1:0] != 2'b00) m_hz = 1;
      else if (f.tahmin_atladi_i != tk || (tk && f.tahmin_adres_i != tg)) begin
        m_mis++; m_pend = 1; m_addr = nx;
      end
    end else if (hs) begin
      m_pend = 0; m_fl = FL;
    end else if (m_fl > 0) begin
      m_fl--;
    end
    m_rdy = !m_pend && (m_fl == 0);
    @(posedge clk); #1;
    chk("hazir",   32'(f.dal_hazir_o),         32'(m_rdy));
    chk("yon_gec", 32'(f.yonlendir_gecerli_o), 32'(m_pend));
    chk("yon_adr", f.yonlendir_adres_o,        m_addr);
    chk("temizle", 32'(f.temizle_o),           32'(m_pend || m_fl > 0));
    chk("bag_gec", 32'(f.baglanti_gecerli_o),  32'(m_bg));
    if (m_bg) chk("baglanti", f.baglanti_o, m_link);
    chk("hizasiz", 32'(f.hizasiz_o),           32'(m_hz));
    chk("dal_say", 32'(f.dal_sayisi_o),        32'(sat(m_cnt, 65535)));
    chk("yanlis",  32'(f.yanlis_tahmin_o),     32'(sat(m_mis, 65535)));
    chk("say2",    32'(g.dal_sayisi_o),        32'(sat(m_cnt, 3)));
    chk("yanlis2", 32'(g.yanlis_tahmin_o),     32'(sat(m_mis, 3)));
    n_yv  += int'(f.yonlendir_gecerli_o);
    n_tem += int'(f.temizle_o);
    @(negedge clk);
  endtask

  task automatic set_op(logic [2:0] t, logic [31:0] pc, logic [31:0] imm,
                        logic [31:0] a, logic [31:0] b, logic pt, logic [31:0] pa);
    f.dal_gecerli_i = 1'b1; f.dal_turu_i = t; f.adres_i = pc; f.anlik_i = imm;
    f.yazmac_degeri1_i = a; f.yazmac_degeri2_i = b;
    f.tahmin_atladi_i = pt; f.tahmin_adres_i = pa;
  endtask

  task automatic idle();
    f.dal_gecerli_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit tk;
    logic [31:0] tg, nx, r;
    idle();
    set_op(0, 0, 0, 0, 0, 0, 0); idle();
    f.yonlendir_hazir_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_hazir", 32'(f.dal_hazir_o), 0);
    chk("rst_yon",   32'(f.yonlendir_gecerli_o), 0);
    chk("rst_tem",   32'(f.temizle_o), 0);
    rst_n = 1'b1;
    step();

    // BEQ predicted correctly
    set_op(0, 32'h100, 32'h20, 5, 5, 1, 32'h120); step(); idle(); step();
    chk("beq_cnt", 32'(f.dal_sayisi_o), 1);

    // BLT mispredict, redirect accepted after 3 waiting cycles
    n_yv = 0; n_tem = 0;
    set_op(2, 32'h200, 32'h40, 32'hFFFF_FFFF, 1, 0, 0); step(); idle();
    chk("blt_adr", f.yonlendir_adres_o, 32'h240);
    repeat (3) step();
    f.yonlendir_hazir_i = 1'b1; step(); f.yonlendir_hazir_i = 1'b0;
    repeat (3) step();
    chk("blt_yv_len",  32'(n_yv), 4);
    chk("blt_tem_len", 32'(n_tem), 6);

    // BLTU same operands: not taken, predicted not taken
    set_op(4, 32'h200, 32'h40, 32'hFFFF_FFFF, 1, 0, 0); step(); idle();
    chk("bltu_nored", 32'(f.yonlendir_gecerli_o), 0);
    step();

    // JALR with odd rs1
    set_op(7, 32'h300, 32'h4, 32'h1001, 0, 1, 32'h1004); step(); idle();
    chk("jalr_link", f.baglanti_o, 32'h304);
    step();

    // JAL to misaligned target
    set_op(6, 32'h400, 32'h6, 0, 0, 0, 0); step(); idle();
    chk("jal_hz",   32'(f.hizasiz_o), 1);
    chk("jal_link", f.baglanti_o, 32'h404);
    step();

    // reset during a pending redirect
    set_op(1, 32'h500, 32'h10, 1, 2, 0, 0); step(); idle();
    rst_n = 1'b0; #1;
    chk("arst_yon",  32'(f.yonlendir_gecerli_o), 0);
    chk("arst_tem",  32'(f.temizle_o), 0);
    chk("arst_cnt",  32'(f.dal_sayisi_o), 0);
    chk("arst_hazir", 32'(f.dal_hazir_o), 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1; model_reset();
    step();
    chk("post_hazir", 32'(f.dal_hazir_o), 1);

    // five mispredicts with immediate handshake: 2-bit counter saturates
    f.yonlendir_hazir_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_op(0, 32'h600 + 32'(i) * 4, 32'h8, 7, 7, 0, 0); step(); idle();
      for (int w = 0; w < 10 && !m_rdy; w++) step();
    end
    f.yonlendir_hazir_i = 1'b0;
    chk("sat_mis2", 32'(g.yanlis_tahmin_o), 3);
    chk("sat_mis",  32'(f.yanlis_tahmin_o), 5);

    // random traffic; a stalled operation is held until accepted
    for (int n = 0; n < 600; n++) begin
      if (!(f.dal_gecerli_i && !m_rdy)) begin
        r = $urandom;
        f.dal_gecerli_i = ($urandom % 4) != 0;
        f.dal_turu_i = 3'($urandom);
        f.adres_i = $urandom & 32'hFFFF_FFFC;
        f.anlik_i = {{20{r[11]}}, r[11:2], 2'b00};
        if ($urandom % 8 == 0) f.anlik_i[1] = 1'b1;
        f.yazmac_degeri1_i = ($urandom % 4 == 0) ? 32'($urandom % 4) : $urandom;
        f.yazmac_degeri2_i = ($urandom % 2 == 0) ? f.yazmac_degeri1_i : $urandom;
        ref_op(tk, tg, nx);
        f.tahmin_atladi_i = ($urandom % 4 != 0) ? tk : !tk;
        f.tahmin_adres_i  = ($urandom % 4 != 0) ? tg : $urandom;
      end
      f.yonlendir_hazir_i = $urandom % 2;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
